// File: rtl/fwd_hazard_ctrl_if.sv
// Hazard-unit bundle: ID-stage operand/destination info in, forwarding selects and interlock out.
// With HAZARD_STATS_EN defined it also carries StatClr and StallCnt.
interface fwd_hazard_ctrl_if #(
    parameter int NREG_W = 5,
    parameter int RS_W   = 2
);
    logic              Hold;
    logic              Flush;
    logic              ID_Valid;
    logic [NREG_W-1:0] ID_RS;
    logic [NREG_W-1:0] ID_RT;
    logic              ID_UseRS;
    logic              ID_UseRT;
    logic              ID_WrEn;
    logic [NREG_W-1:0] ID_WrAddr;
    logic [RS_W-1:0]   ID_ResStage;
    logic [RS_W-1:0]   FwdRS;
    logic [RS_W-1:0]   FwdRT;
    logic              Stall;
    logic              BubbleEX;
`ifdef HAZARD_STATS_EN
    logic              StatClr;
    logic [31:0]       StallCnt;
`endif

`ifdef HAZARD_STATS_EN
    modport master (
        output Hold, Flush, ID_Valid, ID_RS, ID_RT, ID_UseRS, ID_UseRT,
               ID_WrEn, ID_WrAddr, ID_ResStage, StatClr,
        input  FwdRS, FwdRT, Stall, BubbleEX, StallCnt
    );
    modport slave (
        input  Hold, Flush, ID_Valid, ID_RS, ID_RT, ID_UseRS, ID_UseRT,
               ID_WrEn, ID_WrAddr, ID_ResStage, StatClr,
        output FwdRS, FwdRT, Stall, BubbleEX, StallCnt
    );
`else
    modport master (
        output Hold, Flush, ID_Valid, ID_RS, ID_RT, ID_UseRS, ID_UseRT,
               ID_WrEn, ID_WrAddr, ID_ResStage,
        input  FwdRS, FwdRT, Stall, BubbleEX
    );
    modport slave (
        input  Hold, Flush, ID_Valid, ID_RS, ID_RT, ID_UseRS, ID_UseRT,
               ID_WrEn, ID_WrAddr, ID_ResStage,
        output FwdRS, FwdRT, Stall, BubbleEX
    );
`endif
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Operand forwarding selects and ID interlock for the ID->EX->MEM1->MEM2->WB pipeline.
// Optional stall counter (StallCnt/StatClr) is enabled by defining HAZARD_STATS_EN.
module fwd_hazard_ctrl #(
    parameter int NREG_W = 5,
    parameter int RS_W   = 2
) (
    input logic              clk,
    input logic              rst,
    fwd_hazard_ctrl_if.slave bus
);
    localparam logic [RS_W-1:0] FWD_GPR = 'd0;
    localparam logic [RS_W-1:0] FWD_WB  = 'd1;
    localparam logic [RS_W-1:0] FWD_M1  = 'd2;
    localparam logic [RS_W-1:0] FWD_M2  = 'd3;

    // E keeps the raw result-stage code; M2 and W are always ready, so they need no rdy bit.
    logic              e_valid, m1_valid, m2_valid, w_valid;
    logic [NREG_W-1:0] e_wa, m1_wa, m2_wa, w_wa;
    logic [RS_W-1:0]   e_res;
    logic              m1_rdy;
    logic              bubble_ex;

    logic              wr;
    logic              stall;
    logic [RS_W:0]     res_rs;
    logic [RS_W:0]     res_rt;

    // Returns {stall, fwd_select}; youngest matching entry wins.
    function automatic logic [RS_W:0] resolve(
        input logic [NREG_W-1:0] src,
        input logic              use_src,
        input logic              ev,  input logic [NREG_W-1:0] ea,
        input logic              m1v, input logic [NREG_W-1:0] m1a, input logic m1r,
        input logic              m2v, input logic [NREG_W-1:0] m2a,
        input logic              wv,  input logic [NREG_W-1:0] wa
    );
        logic [RS_W:0] r;
        r = {1'b0, FWD_GPR};
        if (use_src && (src != '0)) begin
            if (ev && (ea == src))
                r = {1'b1, FWD_GPR};
            else if (m1v && (m1a == src))
                r = m1r ? {1'b0, FWD_M1} : {1'b1, FWD_GPR};
            else if (m2v && (m2a == src))
                r = {1'b0, FWD_M2};
            else if (wv && (wa == src))
                r = {1'b0, FWD_WB};
        end
        return r;
    endfunction

    always_comb begin
        wr     = bus.ID_Valid && bus.ID_WrEn && (bus.ID_WrAddr != '0);
        res_rs = resolve(bus.ID_RS, bus.ID_UseRS, e_valid, e_wa, m1_valid, m1_wa, m1_rdy,
                         m2_valid, m2_wa, w_valid, w_wa);
        res_rt = resolve(bus.ID_RT, bus.ID_UseRT, e_valid, e_wa, m1_valid, m1_wa, m1_rdy,
                         m2_valid, m2_wa, w_valid, w_wa);
        stall  = bus.ID_Valid && !bus.Flush && (res_rs[RS_W] || res_rt[RS_W]);
    end

    assign bus.FwdRS    = res_rs[RS_W-1:0];
    assign bus.FwdRT    = res_rt[RS_W-1:0];
    assign bus.Stall    = stall;
    assign bus.BubbleEX = bubble_ex;

    // Flush beats Hold; the WB-bound entry still drains so its write-back stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid   <= 1'b0;
            m1_valid  <= 1'b0;
            m2_valid  <= 1'b0;
            w_valid   <= 1'b0;
            e_wa      <= '0;
            m1_wa     <= '0;
            m2_wa     <= '0;
            w_wa      <= '0;
            e_res     <= '0;
            m1_rdy    <= 1'b0;
            bubble_ex <= 1'b0;
        end else if (bus.Flush) begin
            w_valid   <= m2_valid;
            w_wa      <= m2_wa;
            e_valid   <= 1'b0;
            m1_valid  <= 1'b0;
            m2_valid  <= 1'b0;
            bubble_ex <= 1'b1;
        end else if (!bus.Hold) begin
            w_valid   <= m2_valid;
            w_wa      <= m2_wa;
            m2_valid  <= m1_valid;
            m2_wa     <= m1_wa;
            m1_valid  <= e_valid;
            m1_wa     <= e_wa;
            m1_rdy    <= (e_res <= RS_W'(1));
            e_valid   <= wr && !stall;
            e_wa      <= bus.ID_WrAddr;
            e_res     <= bus.ID_ResStage;
            bubble_ex <= stall || !bus.ID_Valid;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || bus.StatClr)
            stall_cnt <= '0;
        else if (stall && !bus.Hold && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign bus.StallCnt = stall_cnt;
`endif

endmodule
